// File: rtl/bcd_pkg.sv
// Shared definitions for the seven-segment display path: nibble width, digit limits,
// slot state encoding and the anode "all off" pattern for either drive polarity.
package bcd_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } slot_state_t;

    function automatic logic [MAX_DIGITS-1:0] ANODE_OFF(input bit active_low);
        return {MAX_DIGITS{active_low}};
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running 0..DIV-1 counter; tick marks the wrap cycle (the slot boundary).
module refresh_prescaler #(
    parameter int unsigned DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [$clog2(DIV)-1:0]  count,
    output logic                    tick
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_scan_control.sv
// Time-multiplexed BCD digit scanner: per-frame snapshot, guard interval, leading-zero
// and mask blanking, decimal-point routing, all outputs registered.
module bcd_scan_control
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned REFRESH_DIV      = 100000,
    parameter int unsigned GUARD_CYCLES     = 1000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          lz_blank_en,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [BCD_W-1:0]              digit,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_index,
    output logic                          frame_start
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned CW = $clog2(REFRESH_DIV);

    localparam logic [MAX_DIGITS-1:0] OFF_ALL   = ANODE_OFF(ANODE_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = OFF_ALL[NUM_DIGITS-1:0];
    localparam logic [IW-1:0] LAST_INDEX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] GUARD_LAST  = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam slot_state_t   SLOT_START  = (GUARD_CYCLES == 0) ? ON : GUARD;

    logic [CW-1:0]               count;
    logic                        tick;
    logic [IW-1:0]               index;
    slot_state_t                 state;
    logic                        first;
    logic                        capture;

    logic [BCD_W*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]       snap_dp;
    logic [NUM_DIGITS-1:0]       snap_en;
    logic                        snap_lz;

    logic [NUM_DIGITS-1:0]       blank;
    logic                        zero_run;
    logic [NUM_DIGITS-1:0]       onehot;
    logic [BCD_W-1:0]            cur_nib;
    logic                        cur_blank;
    logic                        cur_dp;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .count   (count),
        .tick    (tick)
    );

    assign capture = first | (tick & (index == LAST_INDEX));

    // Walk from the most significant digit down; zero_run stays set while every
    // nibble seen so far is zero. Digit 0 is exempt so a zero value still shows "0".
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_run = zero_run & (snap_digits[BCD_W*(NUM_DIGITS-1-k) +: BCD_W] == '0);
            blank[NUM_DIGITS-1-k] = ~snap_en[NUM_DIGITS-1-k]
                                  | (snap_lz & zero_run & (k != NUM_DIGITS - 1));
        end
    end

    always_comb begin
        onehot        = '0;
        onehot[index] = 1'b1;
        cur_nib       = snap_digits[BCD_W*index +: BCD_W];
        cur_blank     = blank[index];
        cur_dp        = snap_dp[index];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            index       <= '0;
            state       <= SLOT_START;
            first       <= 1'b1;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_lz     <= 1'b0;
            anode       <= ANODE_ALL_OFF;
            digit       <= '0;
            dp          <= 1'b0;
            digit_index <= '0;
            frame_start <= 1'b0;
        end else begin
            first <= 1'b0;

            if (capture) begin
                snap_digits <= digits_in;
                snap_dp     <= dp_in;
                snap_en     <= digit_en;
                snap_lz     <= lz_blank_en;
            end

            if (tick) begin
                index <= (index == LAST_INDEX) ? '0 : index + 1'b1;
                state <= SLOT_START;
            end else if ((GUARD_CYCLES != 0) && (count == GUARD_LAST)) begin
                state <= ON;
            end

            // Outputs reflect this cycle's slot; a new snapshot is seen from the next one.
            if ((state == ON) && !cur_blank) begin
                anode <= ANODE_ACTIVE_LOW ? ~onehot : onehot;
            end else begin
                anode <= ANODE_ALL_OFF;
            end
            digit       <= cur_blank ? '0 : cur_nib;
            dp          <= cur_dp & ~cur_blank & (state == ON);
            digit_index <= index;
            frame_start <= capture;
        end
    end

endmodule

// File: tb/tb_bcd_scan_control.sv
// Directed bench for bcd_scan_control with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2,
// active-low anodes. Cycle k counts edges after reset release, k=0 being the first.
module tb_bcd_scan_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank_en;
    logic [3:0]  anode;
    logic [3:0]  digit;
    logic        dp;
    logic [1:0]  digit_index;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_scan_control #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (8),
        .GUARD_CYCLES     (2),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_blank_en (lz_blank_en),
        .anode       (anode),
        .digit       (digit),
        .dp          (dp),
        .digit_index (digit_index),
        .frame_start (frame_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        digits_in = 16'h1234; dp_in = 4'hF; digit_en = 4'hF; lz_blank_en = 1'b0;
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (anode !== 4'b1111) begin bad++; $display("FAIL reset_anode c=%0d got=%b exp=1111", c, anode); end
            total++; if (digit !== 4'h0) begin bad++; $display("FAIL reset_digit c=%0d got=%h exp=0", c, digit); end
            total++; if (dp !== 1'b0) begin bad++; $display("FAIL reset_dp c=%0d got=%b exp=0", c, dp); end
            total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs c=%0d got=%b exp=0", c, frame_start); end
            total++; if (digit_index !== 2'd0) begin bad++; $display("FAIL reset_idx c=%0d got=%0d exp=0", c, digit_index); end
        end
        reset_n = 1'b1;
        step();
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL release_fs got=%b exp=1", frame_start); end
        total++; if (anode !== 4'b1111) begin bad++; $display("FAIL release_anode got=%b exp=1111", anode); end
        step();
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL release_fs2 got=%b exp=0", frame_start); end
        dp_in = 4'h0;
    endtask

    task automatic test_basic_scan();
        logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] dg_tbl [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        logic [3:0] exp_an, exp_dg;
        logic       exp_fs;
        int s, p;
        digits_in = 16'h1234; dp_in = 4'h0; digit_en = 4'hF; lz_blank_en = 1'b0;
        do_reset();
        for (int k = 0; k < 41; k++) begin
            if (k > 0) step();
            s = (k / 8) % 4;
            p = k % 8;
            exp_an = (k == 0 || p < 2) ? 4'b1111 : an_tbl[s];
            exp_dg = (k == 0) ? 4'h0 : dg_tbl[s];
            exp_fs = (k == 0) || (k % 32 == 31);
            total++; if (anode !== exp_an) begin bad++; $display("FAIL scan_anode k=%0d got=%b exp=%b", k, anode, exp_an); end
            total++; if (digit !== exp_dg) begin bad++; $display("FAIL scan_digit k=%0d got=%h exp=%h", k, digit, exp_dg); end
            total++; if (digit_index !== 2'(s)) begin bad++; $display("FAIL scan_idx k=%0d got=%0d exp=%0d", k, digit_index, s); end
            total++; if (frame_start !== exp_fs) begin bad++; $display("FAIL scan_fs k=%0d got=%b exp=%b", k, frame_start, exp_fs); end
            total++; if (dp !== 1'b0) begin bad++; $display("FAIL scan_dp k=%0d got=%b exp=0", k, dp); end
        end
    endtask

    task automatic test_leading_zeros();
        logic [3:0] an_tbl [2][4] = '{'{4'b1110, 4'b1101, 4'b1111, 4'b1111},
                                     '{4'b1110, 4'b1111, 4'b1111, 4'b1111}};
        logic [3:0] dg_tbl [2][4] = '{'{4'h0, 4'h5, 4'h0, 4'h0},
                                     '{4'h0, 4'h0, 4'h0, 4'h0}};
        logic [3:0] exp_an;
        int s, p;
        for (int c = 0; c < 2; c++) begin
            digits_in = (c == 0) ? 16'h0050 : 16'h0000;
            dp_in = 4'h0; digit_en = 4'hF; lz_blank_en = 1'b1;
            do_reset();
            for (int k = 1; k < 33; k++) begin
                step();
                s = (k / 8) % 4;
                p = k % 8;
                exp_an = (p < 2) ? 4'b1111 : an_tbl[c][s];
                total++; if (anode !== exp_an) begin bad++; $display("FAIL lz_anode c=%0d k=%0d got=%b exp=%b", c, k, anode, exp_an); end
                total++; if (digit !== dg_tbl[c][s]) begin bad++; $display("FAIL lz_digit c=%0d k=%0d got=%h exp=%h", c, k, digit, dg_tbl[c][s]); end
            end
        end
    endtask

    task automatic test_tear_free();
        logic [3:0] old_tbl [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        logic [3:0] new_tbl [4] = '{4'h6, 4'h7, 4'h8, 4'h9};
        logic [3:0] exp_dg;
        int s;
        digits_in = 16'h1234; dp_in = 4'h0; digit_en = 4'hF; lz_blank_en = 1'b0;
        do_reset();
        for (int k = 1; k < 64; k++) begin
            step();
            if (k == 12) digits_in = 16'h9876;
            s = (k / 8) % 4;
            exp_dg = (k < 32) ? old_tbl[s] : new_tbl[s];
            total++; if (digit !== exp_dg) begin bad++; $display("FAIL tear_digit k=%0d got=%h exp=%h", k, digit, exp_dg); end
            if (k == 31) begin
                total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL tear_fs k=%0d got=%b exp=1", k, frame_start); end
            end
        end
    endtask

    task automatic test_mask_dp();
        logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b0111};
        logic [3:0] dg_tbl [4] = '{4'h4, 4'h3, 4'h0, 4'h1};
        logic [3:0] exp_an;
        logic       exp_dp;
        int s, p;
        digits_in = 16'h1234; dp_in = 4'b0010; digit_en = 4'b1011; lz_blank_en = 1'b0;
        do_reset();
        for (int k = 1; k < 33; k++) begin
            step();
            s = (k / 8) % 4;
            p = k % 8;
            exp_an = (p < 2) ? 4'b1111 : an_tbl[s];
            exp_dp = (s == 1) && (p >= 2);
            total++; if (anode !== exp_an) begin bad++; $display("FAIL mask_anode k=%0d got=%b exp=%b", k, anode, exp_an); end
            total++; if (digit !== dg_tbl[s]) begin bad++; $display("FAIL mask_digit k=%0d got=%h exp=%h", k, digit, dg_tbl[s]); end
            total++; if (dp !== exp_dp) begin bad++; $display("FAIL mask_dp k=%0d got=%b exp=%b", k, dp, exp_dp); end
        end
    endtask

    task automatic test_mid_reset();
        digits_in = 16'h1234; dp_in = 4'h0; digit_en = 4'hF; lz_blank_en = 1'b0;
        do_reset();
        repeat (20) step();
        total++; if (anode !== 4'b1011) begin bad++; $display("FAIL midrst_pre_anode got=%b exp=1011", anode); end
        total++; if (digit !== 4'h2) begin bad++; $display("FAIL midrst_pre_digit got=%h exp=2", digit); end
        reset_n = 1'b0;
        digits_in = 16'h9876;
        step();
        total++; if (anode !== 4'b1111) begin bad++; $display("FAIL midrst_anode got=%b exp=1111", anode); end
        total++; if (digit !== 4'h0) begin bad++; $display("FAIL midrst_digit got=%h exp=0", digit); end
        total++; if (digit_index !== 2'd0) begin bad++; $display("FAIL midrst_idx got=%0d exp=0", digit_index); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL midrst_fs got=%b exp=0", frame_start); end
        reset_n = 1'b1;
        step();
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL midrst_release_fs got=%b exp=1", frame_start); end
        step();
        step();
        total++; if (anode !== 4'b1110) begin bad++; $display("FAIL midrst_restart_anode got=%b exp=1110", anode); end
        total++; if (digit !== 4'h6) begin bad++; $display("FAIL midrst_restart_digit got=%h exp=6", digit); end
        total++; if (digit_index !== 2'd0) begin bad++; $display("FAIL midrst_restart_idx got=%0d exp=0", digit_index); end
    endtask

    initial begin
        reset_n = 1'b0;
        digits_in = 16'h0000; dp_in = 4'h0; digit_en = 4'h0; lz_blank_en = 1'b0;
        test_reset();
        test_basic_scan();
        test_leading_zeros();
        test_tear_free();
        test_mask_dp();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
